// File: rtl/pcmcia_bus_ctrl.sv
// pcmcia_bus_ctrl: turns Gayle PCMCIA-window CPU requests into timed PC Card cycles.
// Card wait-state support (card_wait input, 256-cycle timeout) is built with `define PCMCIA_WAIT_EN.
//
// state  | meaning
// IDLE   | waiting for cpu_req; misses are acked here without a card cycle
// SETUP  | address, CE1/CE2, REG and write data stable ahead of the strobe
// STROBE | OE/WE or IORD/IOWR asserted; read data captured on the last cycle
// HOLD   | strobe released, address/CE/data still held
// DONE   | CE/REG released, cpu_ack pulse, a new request may be taken

module pcmcia_bus_ctrl #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic [22:0] cpu_addr,
    input  logic        cpu_uds,
    input  logic        cpu_lds,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_data_in,
    output logic [15:0] cpu_data_out,
    output logic        cpu_ack,
    output logic        busy,
    input  logic        card_detect,
`ifdef PCMCIA_WAIT_EN
    input  logic        card_wait,
`endif
    output logic [25:0] card_addr,
    output logic [15:0] card_data_out,
    input  logic [15:0] card_data_in,
    output logic        cc_reg,
    output logic        cc_oe,
    output logic        cc_we,
    output logic        cc_iord,
    output logic        cc_iowr,
    output logic        cc_ce1,
    output logic        cc_ce2
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    localparam logic [3:0] SETUP_LEN  = 4'(SETUP_CYC);
    localparam logic [3:0] STROBE_LEN = 4'(STROBE_CYC);
    localparam logic [3:0] HOLD_LEN   = 4'(HOLD_CYC);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        strobe_done;

    logic        win_common, win_attr, win_io, hit, lds_only;
    logic [25:0] dec_addr;
    logic [15:0] dec_wdata;
    logic        can_accept, take_hit, take_miss;

    logic        l_rw, l_io, l_reg, l_ce2;
    logic [15:0] l_wdata;
    logic        sel_rw, sel_io, sel_reg, sel_ce2;
    logic [15:0] sel_wdata;

    logic        act_nx, str_nx, hold_to_done;
    logic        cd_lost;
    logic [15:0] rd_data;

`ifdef PCMCIA_WAIT_EN
    logic [7:0]  wait_cnt, wait_cnt_nx;
    logic        tmo, tmo_nx;
`else
    logic        tmo;
    assign tmo = 1'b0;
`endif

    // Window decode works on the word address; byte $600000 is word $300000.
    assign win_common = (cpu_addr >= 23'h300000) && (cpu_addr <= 23'h4FFFFF);
    assign win_attr   = (cpu_addr[22:16] == 7'h50);
    assign win_io     = (cpu_addr[22:16] == 7'h51);
    assign lds_only   = cpu_lds & ~cpu_uds;
    assign hit        = (win_common | win_attr | win_io) & card_detect & (cpu_uds | cpu_lds);

    always_comb begin
        dec_addr = {9'b0, cpu_addr[15:0], lds_only};
        if (win_common) begin
            dec_addr = {2'b00, cpu_addr - 23'h300000, lds_only};
        end
    end

    // Byte writes always leave on the low lane; the byte is mirrored onto both halves.
    always_comb begin
        dec_wdata = cpu_data_in;
        if (cpu_uds && !cpu_lds) begin
            dec_wdata = {cpu_data_in[15:8], cpu_data_in[15:8]};
        end else if (lds_only) begin
            dec_wdata = {cpu_data_in[7:0], cpu_data_in[7:0]};
        end
    end

    assign can_accept = (state == IDLE) || (state == DONE);
    assign take_hit   = can_accept & cpu_req & hit;
    assign take_miss  = can_accept & cpu_req & ~hit;

    assign sel_rw    = take_hit ? cpu_rw    : l_rw;
    assign sel_io    = take_hit ? win_io    : l_io;
    assign sel_reg   = take_hit ? ~win_common : l_reg;
    assign sel_ce2   = take_hit ? (cpu_uds & cpu_lds) : l_ce2;
    assign sel_wdata = take_hit ? dec_wdata : l_wdata;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        strobe_done = 1'b0;
`ifdef PCMCIA_WAIT_EN
        wait_cnt_nx = wait_cnt;
        tmo_nx      = tmo;
`endif
        unique case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (take_hit) begin
                    state_nx = SETUP;
                    cnt_nx   = SETUP_LEN;
`ifdef PCMCIA_WAIT_EN
                    wait_cnt_nx = 8'd0;
                    tmo_nx      = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (cnt <= 4'd1) begin
                    state_nx = STROBE;
                    cnt_nx   = STROBE_LEN;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt <= 4'd1) begin
`ifdef PCMCIA_WAIT_EN
                    if (card_wait && (wait_cnt != 8'hFF)) begin
                        wait_cnt_nx = wait_cnt + 8'd1;
                    end else begin
                        strobe_done = 1'b1;
                        tmo_nx      = card_wait;
                    end
`else
                    strobe_done = 1'b1;
`endif
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
                if (strobe_done) begin
                    state_nx = HOLD;
                    cnt_nx   = HOLD_LEN;
                end
            end
            HOLD: begin
                if (cnt <= 4'd1) begin
                    state_nx = DONE;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Card-side outputs are registered from the next state so strobes never glitch.
    assign act_nx       = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
    assign str_nx       = (state_nx == STROBE);
    assign hold_to_done = (state == HOLD) && (state_nx == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            l_rw          <= 1'b0;
            l_io          <= 1'b0;
            l_reg         <= 1'b0;
            l_ce2         <= 1'b0;
            l_wdata       <= 16'h0000;
            cd_lost       <= 1'b0;
            rd_data       <= 16'h0000;
            card_addr     <= 26'h0;
            card_data_out <= 16'h0000;
            cpu_data_out  <= 16'h0000;
            cpu_ack       <= 1'b0;
            busy          <= 1'b0;
            cc_reg        <= 1'b0;
            cc_oe         <= 1'b0;
            cc_we         <= 1'b0;
            cc_iord       <= 1'b0;
            cc_iowr       <= 1'b0;
            cc_ce1        <= 1'b0;
            cc_ce2        <= 1'b0;
`ifdef PCMCIA_WAIT_EN
            wait_cnt      <= 8'd0;
            tmo           <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
`ifdef PCMCIA_WAIT_EN
            wait_cnt <= wait_cnt_nx;
            tmo      <= tmo_nx;
`endif
            if (take_hit) begin
                l_rw      <= cpu_rw;
                l_io      <= win_io;
                l_reg     <= ~win_common;
                l_ce2     <= cpu_uds & cpu_lds;
                l_wdata   <= dec_wdata;
                card_addr <= dec_addr;
            end

            // A card pulled mid-access still completes, but its read data is not trusted.
            if (take_hit) begin
                cd_lost <= 1'b0;
            end else if (busy && !card_detect) begin
                cd_lost <= 1'b1;
            end

            if (strobe_done && l_rw) begin
                rd_data <= l_ce2 ? card_data_in : {card_data_in[7:0], card_data_in[7:0]};
            end

            cc_ce1        <= act_nx;
            cc_ce2        <= act_nx & sel_ce2;
            cc_reg        <= act_nx & sel_reg;
            cc_oe         <= str_nx &  sel_rw & ~sel_io;
            cc_we         <= str_nx & ~sel_rw & ~sel_io;
            cc_iord       <= str_nx &  sel_rw &  sel_io;
            cc_iowr       <= str_nx & ~sel_rw &  sel_io;
            card_data_out <= (act_nx && !sel_rw) ? sel_wdata : 16'h0000;
            busy          <= act_nx;
            cpu_ack       <= take_miss | hold_to_done;

            if (take_miss && cpu_rw) begin
                cpu_data_out <= 16'hFFFF;
            end else if (hold_to_done && l_rw) begin
                cpu_data_out <= (cd_lost || !card_detect || tmo) ? 16'hFFFF : rd_data;
            end
        end
    end

endmodule

// File: tb/tb_pcmcia_bus_ctrl.sv
// Directed bench for pcmcia_bus_ctrl with a transaction-level timing model checked every cycle.
module tb_pcmcia_bus_ctrl;

    localparam int S   = 2;
    localparam int T   = 4;
    localparam int H   = 1;
    localparam int TOT = S + T + H;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [22:0] cpu_addr = '0;
    logic        cpu_uds = 1'b0;
    logic        cpu_lds = 1'b0;
    logic        cpu_rw = 1'b0;
    logic [15:0] cpu_data_in = '0;
    logic [15:0] cpu_data_out;
    logic        cpu_ack;
    logic        busy;
    logic        card_detect = 1'b1;
    logic [25:0] card_addr;
    logic [15:0] card_data_out;
    logic [15:0] card_data_in = '0;
    logic        cc_reg, cc_oe, cc_we, cc_iord, cc_iowr, cc_ce1, cc_ce2;
`ifdef PCMCIA_WAIT_EN
    logic        card_wait = 1'b0;
`endif

    pcmcia_bus_ctrl #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_uds(cpu_uds), .cpu_lds(cpu_lds), .cpu_rw(cpu_rw), .cpu_data_in(cpu_data_in),
        .cpu_data_out(cpu_data_out), .cpu_ack(cpu_ack), .busy(busy), .card_detect(card_detect),
`ifdef PCMCIA_WAIT_EN
        .card_wait(card_wait),
`endif
        .card_addr(card_addr), .card_data_out(card_data_out), .card_data_in(card_data_in),
        .cc_reg(cc_reg), .cc_oe(cc_oe), .cc_we(cc_we), .cc_iord(cc_iord), .cc_iowr(cc_iowr),
        .cc_ce1(cc_ce1), .cc_ce2(cc_ce2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          t0;
        bit          hit;
        bit          rw;
        bit          io;
        bit          rg;
        bit          ce2;
        logic [25:0] ca;
        logic [15:0] wd;
        logic [15:0] rd;
    } acc_t;

    acc_t        q[$];
    logic [15:0] exp_dout = 16'h0000;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Expected access derived from the window/lane rules on the byte address.
    function automatic acc_t model(input int t0, input logic [22:0] a, input logic uds, input logic lds,
                                   input logic rw, input logic cd, input logic [15:0] wd,
                                   input logic [15:0] cdin, input bit drop);
        acc_t r;
        int   ba;
        int   off;
        ba     = int'(a) * 2;
        r.t0   = t0;
        r.rw   = rw;
        r.hit  = cd && (uds || lds) &&
                 ((ba >= 'h600000 && ba <= 'h9FFFFF) || (ba >= 'hA00000 && ba <= 'hA3FFFF));
        r.io   = (ba >= 'hA20000);
        r.rg   = (ba >= 'hA00000);
        r.ce2  = uds && lds;
        off    = (ba < 'hA00000) ? ba - 'h600000 : ba % 'h20000;
        if (lds && !uds) off = off + 1;
        r.ca   = 26'(off);
        r.wd   = r.ce2 ? wd : (uds ? {wd[15:8], wd[15:8]} : {wd[7:0], wd[7:0]});
        if (!r.hit || drop)  r.rd = 16'hFFFF;
        else if (r.ce2)      r.rd = cdin;
        else                 r.rd = {cdin[7:0], cdin[7:0]};
        return r;
    endfunction

    always @(negedge clk) begin
        logic        e_busy, e_ack, e_oe, e_we, e_iord, e_iowr, e_ce1, e_ce2, e_reg, a_on;
        logic [15:0] e_cdo;
        logic [25:0] e_ca;
        int          k;
        {e_busy, e_ack, e_oe, e_we, e_iord, e_iowr, e_ce1, e_ce2, e_reg, a_on} = '0;
        e_cdo = '0;
        e_ca  = '0;
        if (reset_n) begin
            foreach (q[i]) begin
                k = cyc - q[i].t0;
                if (q[i].hit) begin
                    if (k >= 1 && k <= TOT) begin
                        e_busy = 1'b1;
                        e_ce1  = 1'b1;
                        e_ce2  = q[i].ce2;
                        e_reg  = q[i].rg;
                        a_on   = 1'b1;
                        e_ca   = q[i].ca;
                        if (!q[i].rw) e_cdo = q[i].wd;
                    end
                    if (k > S && k <= S + T) begin
                        e_oe   = q[i].rw && !q[i].io;
                        e_we   = !q[i].rw && !q[i].io;
                        e_iord = q[i].rw && q[i].io;
                        e_iowr = !q[i].rw && q[i].io;
                    end
                    if (k == TOT + 1) begin
                        e_ack = 1'b1;
                        if (q[i].rw) exp_dout = q[i].rd;
                    end
                end else if (k == 1) begin
                    e_ack = 1'b1;
                    if (q[i].rw) exp_dout = 16'hFFFF;
                end
            end
            while (q.size() > 0 && (cyc - q[0].t0) > TOT + 1) void'(q.pop_front());
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("cpu_ack", 32'(cpu_ack), 32'(e_ack));
        chk("strobes", {28'b0, cc_oe, cc_we, cc_iord, cc_iowr}, {28'b0, e_oe, e_we, e_iord, e_iowr});
        chk("ce_reg", {29'b0, cc_ce1, cc_ce2, cc_reg}, {29'b0, e_ce1, e_ce2, e_reg});
        chk("card_data_out", 32'(card_data_out), 32'(e_cdo));
        chk("cpu_data_out", 32'(cpu_data_out), 32'(exp_dout));
        if (a_on) chk("card_addr", 32'(card_addr), 32'(e_ca));
        if (cc_oe && cc_we) chk("oe_we_overlap", 32'd1, 32'd0);
    end

    // Observations of the last access, used for literal expectations.
    int          o_lat, o_first, o_oe, o_we, o_iord, o_iowr, o_act;
    logic [25:0] o_addr;
    logic        o_ce2, o_reg;
    logic [15:0] o_cdo;

    task automatic access(input logic [22:0] a, input logic uds, input logic lds, input logic rw,
                          input logic [15:0] wd, input logic [15:0] cdin, input int drop);
        acc_t r;
        card_data_in = cdin;
        cpu_addr     = a;
        cpu_uds      = uds;
        cpu_lds      = lds;
        cpu_rw       = rw;
        cpu_data_in  = wd;
        cpu_req      = 1'b1;
        r = model(cyc, a, uds, lds, rw, card_detect, wd, cdin, drop > 0);
        q.push_back(r);
        {o_oe, o_we, o_iord, o_iowr, o_act} = '0;
        o_lat   = -1;
        o_first = -1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n == drop) card_detect = 1'b0;
            if (n == 1) begin
                o_addr = card_addr;
                o_ce2  = cc_ce2;
                o_reg  = cc_reg;
                o_cdo  = card_data_out;
            end
            if (cc_oe)   o_oe++;
            if (cc_we)   o_we++;
            if (cc_iord) o_iord++;
            if (cc_iowr) o_iowr++;
            if ((cc_oe | cc_we | cc_iord | cc_iowr) && o_first < 0) o_first = n;
            if (cc_ce1 | cc_ce2 | cc_reg | cc_oe | cc_we | cc_iord | cc_iowr) o_act++;
            if (cpu_ack) begin
                o_lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        card_detect = 1'b1;
        if (o_lat < 0) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int t_ack1, ack_seen;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_card_addr", 32'(card_addr), 32'd0);
        chk("rst_dout", 32'(cpu_data_out), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Attribute word read at $A00000.
        access(23'h500000, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0012, 0);
        chk("wr_lat", 32'(o_lat), 32'd8);
        chk("wr_oe_first", 32'(o_first), 32'd3);
        chk("wr_oe_len", 32'(o_oe), 32'd4);
        chk("wr_addr", 32'(o_addr), 32'h0);
        chk("wr_ce2_reg", {30'b0, o_ce2, o_reg}, 32'd3);
        chk("wr_data", 32'(cpu_data_out), 32'h0012);
        idle(2);

        // Attribute byte write at $A01000, upper lane.
        access(23'h500800, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 0);
        chk("aw_lat", 32'(o_lat), 32'd8);
        chk("aw_addr", 32'(o_addr), 32'h1000);
        chk("aw_ce2", 32'(o_ce2), 32'd0);
        chk("aw_cdo_lo", 32'(o_cdo[7:0]), 32'h01);
        chk("aw_we_len", 32'(o_we), 32'd4);
        idle(1);

        // IO odd byte read at $A20003.
        access(23'h510001, 1'b0, 1'b1, 1'b1, 16'h0000, 16'hAA05, 0);
        chk("io_iord", 32'(o_iord), 32'd4);
        chk("io_oe", 32'(o_oe), 32'd0);
        chk("io_addr", 32'(o_addr), 32'h3);
        chk("io_data", 32'(cpu_data_out), 32'h0505);
        idle(1);

        // Misses: outside windows, no card, no lanes, just below common window.
        access(23'h580000, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h1234, 0);
        chk("miss_lat", 32'(o_lat), 32'd1);
        chk("miss_act", 32'(o_act), 32'd0);
        chk("miss_data", 32'(cpu_data_out), 32'hFFFF);
        idle(1);
        card_detect = 1'b0;
        access(23'h500000, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h1234, 0);
        chk("nocd_lat", 32'(o_lat), 32'd1);
        chk("nocd_act", 32'(o_act), 32'd0);
        idle(1);
        access(23'h500000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234, 0);
        chk("nolane_lat", 32'(o_lat), 32'd1);
        idle(1);
        access(23'h2FFFFF, 1'b1, 1'b0, 1'b0, 16'h5555, 16'h0000, 0);
        chk("below_common_lat", 32'(o_lat), 32'd1);
        chk("below_common_act", 32'(o_act), 32'd0);
        idle(1);

        // Common memory word write at $612344 and top-of-window byte read $9FFFFF.
        access(23'h3091A2, 1'b1, 1'b1, 1'b0, 16'hBEEF, 16'h0000, 0);
        chk("cw_addr", 32'(o_addr), 32'h12344);
        chk("cw_cdo", 32'(o_cdo), 32'hBEEF);
        chk("cw_reg", 32'(o_reg), 32'd0);
        idle(1);
        access(23'h4FFFFF, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h3C7E, 0);
        chk("ctop_addr", 32'(o_addr), 32'h3FFFFF);
        chk("ctop_data", 32'(cpu_data_out), 32'h7E7E);
        idle(1);

        // Card removed mid-access: completes, data forced to $FFFF.
        access(23'h300010, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h4321, 4);
        chk("cdrop_lat", 32'(o_lat), 32'd8);
        chk("cdrop_data", 32'(cpu_data_out), 32'hFFFF);
        idle(1);

        // Reset during STROBE.
        card_data_in = 16'h0F0F;
        cpu_addr = 23'h500000; cpu_uds = 1'b1; cpu_lds = 1'b1; cpu_rw = 1'b1; cpu_req = 1'b1;
        q.push_back(model(cyc, 23'h500000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0F0F, 1'b0));
        @(posedge clk); #1;
        cpu_req = 1'b0;
        idle(3);
        chk("rs_oe_before", 32'(cc_oe), 32'd1);
        #1;
        reset_n = 1'b0;
        q.delete();
        exp_dout = 16'h0000;
        #1;
        chk("rs_oe", 32'(cc_oe), 32'd0);
        chk("rs_ce", {30'b0, cc_ce1, cc_ce2}, 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        idle(2);
        reset_n = 1'b1;
        ack_seen = 0;
        for (int n = 0; n < 12; n++) begin
            if (cpu_ack) ack_seen++;
            @(posedge clk); #1;
        end
        chk("rs_no_ack", 32'(ack_seen), 32'd0);
        access(23'h500000, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h00C3, 0);
        chk("rs_next_lat", 32'(o_lat), 32'd8);
        chk("rs_next_data", 32'(cpu_data_out), 32'h00C3);
        idle(2);

        // Back-to-back: second request issued in the DONE cycle of the first.
        access(23'h500002, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h1111, 0);
        t_ack1 = cyc;
        chk("b2b_first_data", 32'(cpu_data_out), 32'h1111);
        access(23'h500004, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h2222, 0);
        chk("b2b_spacing", 32'(cyc - t_ack1), 32'd8);
        chk("b2b_oe_len", 32'(o_oe), 32'd4);
        chk("b2b_second_data", 32'(cpu_data_out), 32'h2222);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
